sd_out_collector: RTL
=====================

SD_OUT_COLLECTOR -- requirements
Module: sd_out_collector

Interface
REQ-001 Parameter GL_CNTR_W, 16, width of the internal schedule counter.
REQ-002 Parameter DATAW, 32, data word width.
REQ-003 Parameter SD, 13, non-stalled cycles after reset before the first output word is valid; range 0 to 2^GL_CNTR_W-1.
REQ-004 Parameter AFI, 10, non-stalled cycles between successive valid output words; minimum 1.
REQ-005 Parameter NOUT, 4, number of words to collect per run; minimum 1.
REQ-006 Parameter AW, 3, FIFO address width; depth is 2^AW.
REQ-007 clk  input  1  clock; all logic on the rising edge.
REQ-008 rst  input  1  reset, synchronous, active-high.
REQ-009 stall  input  1  synchronous-domain stall, the same signal that drives the upstream stages.
REQ-010 datain  input  DATAW  output word from the last upstream stage.
REQ-011 rd_en  input  1  pop request from the consumer.
REQ-012 rd_data  output  DATAW  popped word, registered.
REQ-013 rd_valid  output  1  rd_data holds a word popped in the previous cycle.
REQ-014 empty  output  1  FIFO holds 0 words.
REQ-015 full  output  1  FIFO holds 2^AW words.
REQ-016 count  output  AW+1  FIFO occupancy.
REQ-017 done  output  1  NOUT capture slots have passed.
REQ-018 overflow  output  1  sticky flag: a capture was dropped.
REQ-019 checksum  output  DATAW  running checksum of captured words; see Configuration.

Function
REQ-020 cnt SHALL increment by 1 on each cycle with stall=0 while in state WAIT, and SHALL hold when stall=1 or in any other state.
REQ-021 The FSM SHALL have three states: WAIT, COLLECT and DONE.
REQ-022 WAIT: on a cycle with stall=0 and cnt==SD, the block SHALL capture datain, set k=1 and phase=0, and go to DONE if NOUT==1, otherwise go to COLLECT.
REQ-023 COLLECT: on each cycle with stall=0, phase SHALL increment; when phase==AFI-1, the block SHALL capture datain, clear phase and increment k.
REQ-024 COLLECT SHALL go to DONE on the capture that makes k==NOUT.
REQ-025 DONE SHALL hold until rst, with done=1 and no further captures.
REQ-026 A stalled cycle SHALL never capture and SHALL never advance cnt, phase or k.
REQ-027 A capture SHALL write datain into the FIFO tail in the same edge.
REQ-028 If a capture occurs while full=1 and there is no simultaneous pop, the word SHALL be dropped and overflow SHALL set and remain 1 until rst.
REQ-029 A pop SHALL occur when rd_en=1 and empty=0; rd_data SHALL update on that edge and rd_valid SHALL be 1 for the following cycle only.
REQ-030 rd_en while empty SHALL be ignored: rd_valid=0, rd_data holds.
REQ-031 A simultaneous capture and pop SHALL both succeed, including when full=1; count is unchanged.
REQ-032 Pointers SHALL wrap modulo 2^AW; count SHALL be exact from 0 to 2^AW.
REQ-033 empty, full and count SHALL be registered and consistent in every cycle.

Reset
REQ-034 On rst=1, at the next edge the block SHALL set: state=WAIT, cnt=0, phase=0, k=0, FIFO empty, count=0, empty=1, full=0, done=0, overflow=0, rd_valid=0, rd_data=0, checksum=0.
REQ-035 rst SHALL take priority over capture, pop and stall, including when asserted mid-COLLECT or with the FIFO full; FIFO contents are discarded.

Configuration
REQ-036 Macro SD_COLLECT_CHECKSUM_EN.
REQ-037 When defined, each accepted capture (dropped words excluded) SHALL update checksum to checksum XOR datain on the same edge.
REQ-038 When not defined, checksum SHALL be constant 0 and no checksum register SHALL be built; all other behaviour is identical.

Verification
REQ-039 Defaults, stall=0, datain = cycle index: captures at non-stalled cycles 13, 23, 33, 43; done=1 after the 43rd; draining with rd_en returns 13, 23, 33, 43.
REQ-040 Stall held high 5 cycles starting at non-stalled cycle 20: captures occur at the same non-stalled counts, i.e. absolute cycles 13, 28, 38, 48.
REQ-041 AW=1, NOUT=4, AFI=1, SD=0, rd_en=0: first 2 words stored, full=1, overflow=1 after capture 3, count=2.
REQ-042 Full FIFO with rd_en=1 on a capture cycle: both succeed, count unchanged, overflow stays 0.
REQ-043 rst pulsed in COLLECT after 2 captures: all outputs return to REQ-034 values; the rerun captures at non-stalled cycles 13, 23, 33, 43 relative to reset release.
REQ-044 With SD_COLLECT_CHECKSUM_EN, words 0x1, 0x2, 0x4, 0x8: checksum=0xF at done; without the macro, checksum=0.

Source files
------------

// File: rtl/sd_out_collector.sv
// sd_out_collector: samples the last pipeline stage on a fixed schedule
// (first word SD non-stalled cycles after reset, then every AFI non-stalled
// cycles, NOUT words in total) and queues the samples in a small FIFO.
// Latency: a capture is written to the FIFO on the edge where it occurs; a
// pop registers rd_data on its edge, and rd_valid is high for the next cycle.
// Backpressure: none towards upstream. A capture into a full FIFO without a
// simultaneous pop is dropped and sets the sticky overflow flag.
// Ports: clk, rst (sync, active-high), stall, datain -> schedule/capture;
//        rd_en -> rd_data/rd_valid; empty/full/count occupancy;
//        done, overflow, checksum status.
// Optional feature: define SD_COLLECT_CHECKSUM_EN to build a running XOR of
// accepted captures on checksum; otherwise checksum is tied to 0.
module sd_out_collector #(
   parameter int GL_CNTR_W = 16,
   parameter int DATAW     = 32,
   parameter int SD        = 13,
   parameter int AFI       = 10,
   parameter int NOUT      = 4,
   parameter int AW        = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic [DATAW-1:0] datain,
   input  logic             rd_en,
   output logic [DATAW-1:0] rd_data,
   output logic             rd_valid,
   output logic             empty,
   output logic             full,
   output logic [AW:0]      count,
   output logic             done,
   output logic             overflow,
   output logic [DATAW-1:0] checksum
);

   localparam int DEPTH = 2 ** AW;
   localparam int PW    = (AFI > 1) ? $clog2(AFI) : 1;
   localparam int KW    = $clog2(NOUT + 1);

   localparam logic [GL_CNTR_W-1:0] SD_C    = GL_CNTR_W'(SD);
   localparam logic [PW-1:0]        AFI_M1  = PW'(AFI - 1);
   localparam logic [KW-1:0]        NOUT_M1 = KW'(NOUT - 1);
   localparam logic [AW:0]          DEPTH_C = (AW + 1)'(DEPTH);

   typedef enum logic [1:0] {S_WAIT, S_COLLECT, S_DONE} state_t;

   state_t               state;
   logic [GL_CNTR_W-1:0] cnt;
   logic [PW-1:0]        phase;
   logic [KW-1:0]        k;

   logic [DATAW-1:0]     mem [DEPTH];
   logic [AW-1:0]        wr_ptr;
   logic [AW-1:0]        rd_ptr;
   logic [AW:0]          count_nxt;

   logic capture;
   logic pop;
   logic push;
   logic drop;

   // A capture slot is purely a function of the schedule; stalled cycles never capture.
   always_comb begin
      capture = 1'b0;
      if (!stall) begin
         case (state)
            S_WAIT:    capture = (cnt == SD_C);
            S_COLLECT: capture = (phase == AFI_M1);
            default:   capture = 1'b0;
         endcase
      end
   end

   // A pop on the same edge frees the slot, so a full FIFO still accepts the capture.
   assign pop  = rd_en & ~empty;
   assign push = capture & (~full | pop);
   assign drop = capture & full & ~pop;

   always_comb begin
      count_nxt = count;
      case ({push, pop})
         2'b10:   count_nxt = count + 1'b1;
         2'b01:   count_nxt = count - 1'b1;
         default: count_nxt = count;
      endcase
   end

   // Schedule FSM with registered done.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_WAIT;
         cnt   <= '0;
         phase <= '0;
         k     <= '0;
         done  <= 1'b0;
      end else if (!stall) begin
         case (state)
            S_WAIT: begin
               cnt <= cnt + 1'b1;
               if (cnt == SD_C) begin
                  k     <= KW'(1);
                  phase <= '0;
                  if (NOUT == 1) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= S_COLLECT;
                  end
               end
            end
            S_COLLECT: begin
               if (phase == AFI_M1) begin
                  phase <= '0;
                  k     <= k + 1'b1;
                  if (k == NOUT_M1) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end
               end else begin
                  phase <= phase + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Storage carries no reset; resetting the pointers discards its contents.
   always_ff @(posedge clk) begin
      if (push && !rst) mem[wr_ptr] <= datain;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         empty    <= 1'b1;
         full     <= 1'b0;
         overflow <= 1'b0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            // Reads the pre-edge word even when a full-FIFO push targets the same slot.
            rd_data <= mem[rd_ptr];
            rd_ptr  <= rd_ptr + 1'b1;
         end
         rd_valid <= pop;
         if (drop) overflow <= 1'b1;
         count <= count_nxt;
         empty <= (count_nxt == '0);
         full  <= (count_nxt == DEPTH_C);
      end
   end

`ifdef SD_COLLECT_CHECKSUM_EN
   always_ff @(posedge clk) begin
      if (rst)       checksum <= '0;
      else if (push) checksum <= checksum ^ datain;
   end
`else
   assign checksum = '0;
`endif

endmodule
